seg_display_scanner: RTL and testbench

//  Time-multiplexed 8-digit 7-segment driver downstream of the two player

---
 rtl/seg_display_scanner_if.sv | 20 ++
 rtl/seg_display_scanner.sv | 118 +++++++++++
 tb/tb_seg_display_scanner.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_scanner_if.sv
// Bus between the chess-clock counters and the multiplexed 8-digit display scanner.
// The master drives the digit data and controls; the slave (scanner) drives the display pins.
interface seg_display_scanner_if;
  logic        ce_i;
  logic [31:0] digits_i;
  logic [7:0]  blink_mask_i;
  logic        lzb_en_i;
  logic [6:0]  seg_out_o;
  logic [7:0]  seg_select_o;

  modport master (
    output ce_i, digits_i, blink_mask_i, lzb_en_i,
    input  seg_out_o, seg_select_o
  );

  modport slave (
    input  ce_i, digits_i, blink_mask_i, lzb_en_i,
    output seg_out_o, seg_select_o
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 8-digit 7-segment scanner with dead cycle, per-digit blink and
// per-group leading-zero blanking. Segments and anodes are active-low and registered.
module seg_display_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_scanner_if.slave scan_if
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p_q, p_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          bp_q, bp_d;
  logic [7:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0]    curNib;
  logic [3:0]    pos3Nib;
  logic [3:0]    pos2Nib;
  logic          lzbBlank;
  logic          blinkBlank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h3F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Outputs are decoded from the next-state scan position so they line up with it.
  always_comb begin
    p_d        = p_q;
    idx_d      = idx_q;
    fc_d       = fc_q;
    bp_d       = bp_q;
    sel_d      = sel_q;
    seg_d      = seg_q;
    curNib     = 4'h0;
    pos3Nib    = 4'h0;
    pos2Nib    = 4'h0;
    lzbBlank   = 1'b0;
    blinkBlank = 1'b0;

    if (scan_if.ce_i) begin
      if (p_q == P_LAST) begin
        p_d   = '0;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          if (fc_q == F_LAST) begin
            fc_d = '0;
            bp_d = ~bp_q;
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
      end else begin
        p_d = p_q + 1'b1;
      end

      if (p_d == '0) begin
        sel_d = 8'hFF;
        seg_d = 7'h7F;
      end else begin
        curNib  = scan_if.digits_i[{idx_d, 2'b00} +: 4];
        // Group A is digits 7..4, group B is 3..0; only the top two positions blank.
        pos3Nib = idx_d[2] ? scan_if.digits_i[31:28] : scan_if.digits_i[15:12];
        pos2Nib = idx_d[2] ? scan_if.digits_i[27:24] : scan_if.digits_i[11:8];
        lzbBlank = scan_if.lzb_en_i &&
                   (((idx_d[1:0] == 2'd3) && (pos3Nib == 4'h0)) ||
                    ((idx_d[1:0] == 2'd2) && (pos3Nib == 4'h0) && (pos2Nib == 4'h0)));
        blinkBlank = bp_d && scan_if.blink_mask_i[idx_d];
        sel_d = ~(8'b1 << idx_d);
        seg_d = (lzbBlank || blinkBlank) ? 7'h7F : decode(curNib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      idx_q <= 3'd0;
      fc_q  <= '0;
      bp_q  <= 1'b0;
      sel_q <= 8'hFF;
      seg_q <= 7'h7F;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
      fc_q  <= fc_d;
      bp_q  <= bp_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign scan_if.seg_select_o = sel_q;
  assign scan_if.seg_out_o    = seg_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_display_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  seg_display_scanner_if bus ();

  seg_display_scanner #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_if(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ce_i = 1'b0;
    bus.digits_i = 32'h0123_4567;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ce_i = ~bus.ce_i;
      tick();
      total++;
      if (bus.seg_select_o !== 8'hFF || bus.seg_out_o !== 7'h7F) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc=%0d sel=%h seg=%h want sel=ff seg=7f",
                 i, bus.seg_select_o, bus.seg_out_o);
      end
    end
    rst = 1'b0;
    bus.ce_i = 1'b1;
    repeat (10) tick();
    total++;
    if (bus.seg_select_o !== 8'hFB || bus.seg_out_o !== 7'h12) begin
      bad++;
      $display("[TB] FAIL pre_midreset sel=%h seg=%h want sel=fb seg=12",
               bus.seg_select_o, bus.seg_out_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.seg_select_o !== 8'hFF || bus.seg_out_o !== 7'h7F) begin
      bad++;
      $display("[TB] FAIL async_reset sel=%h seg=%h want sel=ff seg=7f",
               bus.seg_select_o, bus.seg_out_o);
    end
  endtask

  task automatic test_scan();
    logic [6:0] tab [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [7:0] expSel;
    logic [6:0] expSeg;
    int idx;
    bus.digits_i = 32'h0123_4567;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b0;
    do_reset();
    bus.ce_i = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      idx = (e / 4) % 8;
      if (e % 4 == 0) begin
        expSel = 8'hFF;
        expSeg = 7'h7F;
      end else begin
        expSel = ~(8'b1 << idx);
        expSeg = tab[idx];
      end
      total++;
      if (bus.seg_select_o !== expSel || bus.seg_out_o !== expSeg) begin
        bad++;
        $display("[TB] FAIL scan edge=%0d sel=%h seg=%h want sel=%h seg=%h",
                 e, bus.seg_select_o, bus.seg_out_o, expSel, expSeg);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] tab [8] = '{7'h40, 7'h40, 7'h79, 7'h7F, 7'h12, 7'h40, 7'h7F, 7'h7F};
    logic [7:0] expSel;
    int idx;
    bus.digits_i = 32'h0005_0100;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b1;
    do_reset();
    bus.ce_i = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      idx = (e / 4) % 8;
      if (e % 4 != 0) begin
        expSel = ~(8'b1 << idx);
        total++;
        if (bus.seg_select_o !== expSel || bus.seg_out_o !== tab[idx]) begin
          bad++;
          $display("[TB] FAIL lzb digit=%0d sel=%h seg=%h want sel=%h seg=%h",
                   idx, bus.seg_select_o, bus.seg_out_o, expSel, tab[idx]);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] tab [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [7:0] expSel;
    logic [6:0] expSeg;
    int idx;
    int frame;
    bus.digits_i = 32'h0123_4567;
    bus.blink_mask_i = 8'hF0;
    bus.lzb_en_i = 1'b0;
    do_reset();
    bus.ce_i = 1'b1;
    for (int e = 1; e <= 160; e++) begin
      tick();
      idx = (e / 4) % 8;
      frame = e / 32;
      if (e % 4 == 0) begin
        expSel = 8'hFF;
        expSeg = 7'h7F;
      end else begin
        expSel = ~(8'b1 << idx);
        expSeg = (((frame / 2) % 2 == 1) && idx >= 4) ? 7'h7F : tab[idx];
      end
      total++;
      if (bus.seg_select_o !== expSel || bus.seg_out_o !== expSeg) begin
        bad++;
        $display("[TB] FAIL blink edge=%0d frame=%0d sel=%h seg=%h want sel=%h seg=%h",
                 e, frame, bus.seg_select_o, bus.seg_out_o, expSel, expSeg);
      end
    end
    bus.blink_mask_i = 8'h00;
  endtask

  task automatic test_ce_hold();
    logic [7:0] selSeq [3] = '{8'hF7, 8'hFF, 8'hEF};
    logic [6:0] segSeq [3] = '{7'h19, 7'h7F, 7'h30};
    bus.digits_i = 32'h0123_4567;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b0;
    do_reset();
    bus.ce_i = 1'b1;
    repeat (14) tick();
    bus.ce_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.seg_select_o !== 8'hF7 || bus.seg_out_o !== 7'h19) begin
        bad++;
        $display("[TB] FAIL ce_hold cyc=%0d sel=%h seg=%h want sel=f7 seg=19",
                 i, bus.seg_select_o, bus.seg_out_o);
      end
    end
    bus.ce_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.seg_select_o !== selSeq[i] || bus.seg_out_o !== segSeq[i]) begin
        bad++;
        $display("[TB] FAIL ce_resume step=%0d sel=%h seg=%h want sel=%h seg=%h",
                 i, bus.seg_select_o, bus.seg_out_o, selSeq[i], segSeq[i]);
      end
    end
  endtask

  task automatic test_dash_blank();
    bus.digits_i = 32'h0000_00FA;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b0;
    do_reset();
    bus.ce_i = 1'b1;
    tick();
    total++;
    if (bus.seg_select_o !== 8'hFE || bus.seg_out_o !== 7'h3F) begin
      bad++;
      $display("[TB] FAIL dash sel=%h seg=%h want sel=fe seg=3f",
               bus.seg_select_o, bus.seg_out_o);
    end
    repeat (4) tick();
    total++;
    if (bus.seg_select_o !== 8'hFD || bus.seg_out_o !== 7'h7F) begin
      bad++;
      $display("[TB] FAIL blank_nibble sel=%h seg=%h want sel=fd seg=7f",
               bus.seg_select_o, bus.seg_out_o);
    end
    repeat (4) tick();
    total++;
    if (bus.seg_select_o !== 8'hFB || bus.seg_out_o !== 7'h40) begin
      bad++;
      $display("[TB] FAIL zero_no_lzb sel=%h seg=%h want sel=fb seg=40",
               bus.seg_select_o, bus.seg_out_o);
    end
  endtask

  initial begin
    bus.ce_i = 1'b0;
    bus.digits_i = 32'h0;
    bus.blink_mask_i = 8'h00;
    bus.lzb_en_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_lzb();
    test_blink();
    test_ce_hold();
    test_dash_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
